// File: rtl/note_recorder.sv
// Note recorder: captures {note, duration} events timed in quarter-beat ticks
// into a register-array buffer and replays them as a third autoplay note source.
module note_recorder #(
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DUR_W  = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              QUARTER_BEAT,
  input  logic              REC,
  input  logic              PLAY,
  input  logic              STOP,
  input  logic [3:0]        in_note,
  output logic [3:0]        out_note,
  output logic              rec_active,
  output logic              play_active,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              done
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [DUR_W-1:0] MAX_DUR = '1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef struct packed {
    logic [3:0]       note;
    logic [DUR_W-1:0] dur;
  } event_t;

  typedef enum logic [1:0] {S_IDLE, S_RECORD, S_PLAY} state_t;

  state_t            state;
  logic              qb_d;
  logic [3:0]        cur_note;
  logic [DUR_W-1:0]  dur;
  logic [ADDR_W-1:0] rd_ptr;
  logic [DUR_W-1:0]  remain;
  event_t            mem [DEPTH];

  logic              tick_c;
  logic              commit_c;
  event_t            commit_ev_c;
  logic [ADDR_W-1:0] nxt_ptr_c;
  event_t            nxt_ev_c;

  assign tick_c    = QUARTER_BEAT & ~qb_d;
  assign nxt_ptr_c = rd_ptr + ADDR_W'(1);
  assign nxt_ev_c  = mem[nxt_ptr_c];

  // Decide whether the pending event is written to the buffer this cycle.
  // A note change sees the pre-tick duration; a tick that reaches the
  // maximum duration splits the note into a full-length event.
  always_comb begin
    commit_c         = 1'b0;
    commit_ev_c.note = cur_note;
    commit_ev_c.dur  = dur;
    if (state == S_RECORD && count < DEPTH_C) begin
      if (STOP || in_note != cur_note) begin
        commit_c = (dur != '0);
      end else if (tick_c && dur == MAX_DUR - DUR_W'(1)) begin
        commit_c        = 1'b1;
        commit_ev_c.dur = MAX_DUR;
      end
    end
  end

  // Event buffer; contents are not reset.
  always_ff @(posedge CLK) begin
    if (commit_c) mem[count[ADDR_W-1:0]] <= commit_ev_c;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= S_IDLE;
      qb_d        <= 1'b0;
      out_note    <= '0;
      rec_active  <= 1'b0;
      play_active <= 1'b0;
      full        <= 1'b0;
      count       <= '0;
      done        <= 1'b0;
      cur_note    <= '0;
      dur         <= '0;
      rd_ptr      <= '0;
      remain      <= '0;
    end else begin
      qb_d <= QUARTER_BEAT;
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!STOP) begin
            if (REC) begin
              state      <= S_RECORD;
              rec_active <= 1'b1;
              count      <= '0;
              full       <= 1'b0;
              cur_note   <= in_note;
              dur        <= '0;
            end else if (PLAY && count != '0) begin
              state       <= S_PLAY;
              play_active <= 1'b1;
              rd_ptr      <= '0;
              out_note    <= mem[0].note;
              remain      <= mem[0].dur;
            end
          end
        end

        S_RECORD: begin
          if (STOP) begin
            state      <= S_IDLE;
            rec_active <= 1'b0;
          end else if (in_note != cur_note) begin
            cur_note <= in_note;
            dur      <= tick_c ? DUR_W'(1) : '0;
          end else if (tick_c) begin
            dur <= (dur == MAX_DUR - DUR_W'(1)) ? '0 : dur + DUR_W'(1);
          end
          // Filling the buffer ends the recording regardless of other activity.
          if (commit_c) begin
            count <= count + CNT_W'(1);
            if (count + CNT_W'(1) == DEPTH_C) begin
              full       <= 1'b1;
              state      <= S_IDLE;
              rec_active <= 1'b0;
            end
          end
        end

        S_PLAY: begin
          if (STOP) begin
            out_note    <= '0;
            state       <= S_IDLE;
            play_active <= 1'b0;
          end else if (tick_c) begin
            if (remain > DUR_W'(1)) begin
              remain <= remain - DUR_W'(1);
            end else if (CNT_W'(rd_ptr) + CNT_W'(1) < count) begin
              rd_ptr   <= nxt_ptr_c;
              out_note <= nxt_ev_c.note;
              remain   <= nxt_ev_c.dur;
            end else begin
              out_note    <= '0;
              done        <= 1'b1;
              state       <= S_IDLE;
              play_active <= 1'b0;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
